// File: rtl/alu_func_pkg.sv
// Shared types for the alu_func registered ALU: opcode width and opcode enum.
package alu_func_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_func_dp.sv
// Combinational datapath of alu_func: next result and status from x, y, opcode.
// Define ALU_FUNC_SAT_EN to make ADD/SUB saturate instead of wrapping.
module alu_func_dp
  import alu_func_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0]    x,
  input  logic [WIDTH-1:0]    y,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [WIDTH-1:0]    result_next,
  output logic                status_next
);

  // One extra bit holds carry-out for ADD and borrow for SUB.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, x} + {1'b0, y};
  assign diff = {1'b0, x} - {1'b0, y};

  always_comb begin
    result_next = '0;
    status_next = 1'b0;
    case (alu_op_e'(opcode))
      OP_ADD: begin
        status_next = sum[WIDTH];
`ifdef ALU_FUNC_SAT_EN
        result_next = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        result_next = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        status_next = diff[WIDTH];
`ifdef ALU_FUNC_SAT_EN
        result_next = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        result_next = diff[WIDTH-1:0];
`endif
      end
      OP_AND: begin
        result_next = x & y;
        status_next = (result_next == '0);
      end
      OP_OR: begin
        result_next = x | y;
        status_next = (result_next == '0);
      end
      OP_XOR: begin
        result_next = x ^ y;
        status_next = (result_next == '0);
      end
      OP_NOT: begin
        result_next = ~x;
        status_next = (result_next == '0);
      end
      OP_SHL: begin
        result_next = {x[WIDTH-2:0], 1'b0};
        status_next = x[WIDTH-1];
      end
      OP_SHR: begin
        result_next = {1'b0, x[WIDTH-1:1]};
        status_next = x[0];
      end
      default: begin
        result_next = '0;
        status_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_func.sv
// Registered 8-function ALU: one-cycle latency, async active-low clear of outputs.
// Optional saturating ADD/SUB via ALU_FUNC_SAT_EN (handled in alu_func_dp).
module alu_func
  import alu_func_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [WIDTH-1:0]    x,
  input  logic [WIDTH-1:0]    y,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [WIDTH-1:0]    result,
  output logic                status
);

  logic [WIDTH-1:0] result_next;
  logic             status_next;

  alu_func_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .x           (x),
    .y           (y),
    .opcode      (opcode),
    .result_next (result_next),
    .status_next (status_next)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      result <= '0;
      status <= 1'b0;
    end else begin
      result <= result_next;
      status <= status_next;
    end
  end

endmodule

// File: tb/tb_alu_func.sv
// Self-checking bench for alu_func: arithmetic reference model, literal anchors, random ops.
module tb_alu_func;

  localparam int W = 13;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [2:0]   opcode = '0;
  logic [W-1:0] result;
  logic         status;

  int     errors = 0;
  int     checks = 0;
  bit     chk_en = 1'b0;
  longint exp_r = 0;
  bit     exp_s = 1'b0;

  always #5 aclk = ~aclk;

  alu_func #(.WIDTH(W)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .x       (x),
    .y       (y),
    .opcode  (opcode),
    .result  (result),
    .status  (status)
  );

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_alu(input int op, input longint a, input longint b,
                                  output longint r, output bit s);
    longint m;
    longint t;
    m = longint'(1) << W;
    r = 0;
    s = 1'b0;
    case (op)
      0: begin
        t = a + b;
        s = (t >= m);
        r = t % m;
`ifdef ALU_FUNC_SAT_EN
        if (s) r = m - 1;
`endif
      end
      1: begin
        s = (a < b);
        r = (a - b + m) % m;
`ifdef ALU_FUNC_SAT_EN
        if (s) r = 0;
`endif
      end
      2: begin r = a & b; s = (r == 0); end
      3: begin r = a | b; s = (r == 0); end
      4: begin r = a ^ b; s = (r == 0); end
      5: begin r = (m - 1) - a; s = (r == 0); end
      6: begin r = (a * 2) % m; s = (a >= m / 2); end
      default: begin r = a / 2; s = (a % 2 == 1); end
    endcase
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    longint r;
    bit     s;
    if (!aresetn) begin
      exp_r <= 0;
      exp_s <= 1'b0;
    end else begin
      ref_alu(int'(opcode), longint'(x), longint'(y), r, s);
      exp_r <= r;
      exp_s <= s;
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      checks++;
      if ({status, result} !== {exp_s, W'(exp_r)}) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got result=%h status=%b, want result=%h status=%b",
                 $time, result, status, W'(exp_r), exp_s);
      end
    end
  end

  task automatic check_lit(input string name, input longint er, input bit es);
    checks++;
    if ({status, result} !== {es, W'(er)}) begin
      errors++;
      $display("FAIL %s t=%0t: got result=%h status=%b, want result=%h status=%b",
               name, $time, result, status, W'(er), es);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  longint sw_r[8] = '{6, 2, 0, 6, 6, 13'h1FFB, 8, 2};
  bit     sw_s[8] = '{0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    aresetn = 1'b0;
    x = 13'd4;
    y = 13'd2;
    opcode = 3'd0;
    @(posedge aclk);
    chk_en = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check_lit("reset_hold", 0, 1'b0);
    end

    // Release between edges: outputs must stay clear until the next rising edge.
    #2 aresetn = 1'b1;
    #1 check_lit("release_before_edge", 0, 1'b0);
    @(negedge aclk);
    check_lit("first_capture_add", 6, 1'b0);

    for (int k = 0; k < 8; k++) begin
      opcode = 3'(k);
      @(negedge aclk);
      check_lit($sformatf("sweep_op%0d", k), sw_r[k], sw_s[k]);
    end

    opcode = 3'd0; x = 13'h1FFF; y = 13'd1;
    @(negedge aclk);
`ifdef ALU_FUNC_SAT_EN
    check_lit("add_carry", 13'h1FFF, 1'b1);
`else
    check_lit("add_carry", 0, 1'b1);
`endif
    opcode = 3'd1; x = 13'd0; y = 13'd1;
    @(negedge aclk);
`ifdef ALU_FUNC_SAT_EN
    check_lit("sub_borrow", 0, 1'b1);
`else
    check_lit("sub_borrow", 13'h1FFF, 1'b1);
`endif
    opcode = 3'd1; x = 13'h0123; y = 13'h0123;
    @(negedge aclk);
    check_lit("sub_equal", 0, 1'b0);
    opcode = 3'd6; x = 13'h1000; y = 13'd0;
    @(negedge aclk);
    check_lit("shl_msb_out", 0, 1'b1);
    opcode = 3'd7; x = 13'h0001;
    @(negedge aclk);
    check_lit("shr_lsb_out", 0, 1'b1);

    opcode = 3'd0; x = 13'd4; y = 13'd2;
    @(negedge aclk);
    check_lit("pre_async_add", 6, 1'b0);
    #2 aresetn = 1'b0;
    #1 check_lit("async_clear", 0, 1'b0);
    @(negedge aclk);
    check_lit("async_held", 0, 1'b0);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    check_lit("after_async_release", 6, 1'b0);

    repeat (400) begin
      @(negedge aclk);
      opcode = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      if ($urandom_range(0, 49) == 0) begin
        #2 aresetn = 1'b0;
        #2 aresetn = 1'b1;
      end
    end
    @(negedge aclk);
    @(negedge aclk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_func.md
Name: alu_func

Overview:
- Registered 8-function integer ALU. It operates on two WIDTH-bit unsigned operands and produces a WIDTH-bit result plus a 1-bit status flag.
- Used as a leaf datapath block; the opcode selects the function each cycle.
- Outputs update on the rising clock edge, so latency is one cycle.

Parameters:
- WIDTH, 13: operand and result width in bits; legal range 2..32.

Ports:
- aclk  input  1  system clock; all state changes on its rising edge.
- aresetn  input  1  asynchronous active-low reset.
- x  input  WIDTH  operand A, unsigned.
- y  input  WIDTH  operand B, unsigned.
- opcode  input  3  function select.
- result  output  WIDTH  registered function result.
- status  output  1  registered flag; meaning depends on opcode (see below).

Interface decision: one clock; reset is asynchronous and active-low (aclk, aresetn).

Behaviour:
- Reset: while aresetn=0, result=0 and status=0, asynchronously. Release is synchronised by the integrator. The first capture happens on the first aclk rising edge with aresetn=1.
- Reset asserted mid-operation clears both outputs immediately; there is no pending state.
- Each rising edge: result and status are loaded from the combinational function of the current x, y, opcode. Latency is exactly 1 cycle; there is no handshake and a new op is accepted every cycle.
- All arithmetic is modulo 2^WIDTH.
- Opcode map (result; status):
  - 0 ADD: x+y; carry-out of bit WIDTH-1.
  - 1 SUB: x-y; borrow (1 when x<y unsigned).
  - 2 AND: x&y; 1 when result==0.
  - 3 OR: x|y; 1 when result==0.
  - 4 XOR: x^y; 1 when result==0.
  - 5 NOT: ~x, y ignored; 1 when result==0.
  - 6 SHL: x<<1, LSB filled with 0; status = x[WIDTH-1], the bit shifted out.
  - 7 SHR: x>>1 logical, MSB filled with 0; status = x[0], the bit shifted out.
- Boundaries:
  - ADD all-ones + 1 -> 0, status 1.
  - SUB 0 - 1 -> all-ones, status 1.
  - SUB x==y -> 0, status 0.
- There is no X-propagation guard; all 8 opcodes are defined, so there is no illegal-opcode case.

Optional Feature:
- Macro ALU_FUNC_SAT_EN.
- When defined: ADD and SUB saturate. ADD with carry gives result = all-ones; SUB with borrow gives result = 0. The status flag is still set exactly as in the non-saturating case.
- When undefined: wrap-around results as specified above.
- Other opcodes are unaffected either way.

Decomposition:
- Package alu_func_pkg holds:
  - opcode enum typedef alu_op_e (OP_ADD=0 .. OP_SHR=7);
  - localparam OPCODE_W=3.
- One natural sub-module: alu_func_dp, a purely combinational datapath (x, y, opcode -> next result, next status).
- alu_func top wraps alu_func_dp with the output register and async reset.

Test Plan:
- Reset: hold aresetn=0 with x=4, y=2, opcode=0 -> result=0, status=0 throughout. Deassert mid-cycle -> still 0 until the next rising edge.
- Opcode sweep, x=4, y=2, opcode stepped 0..7 one per cycle -> results one cycle later:
  - ADD 6 / status 0;
  - SUB 2 / 0;
  - AND 0 / 1;
  - OR 6 / 0;
  - XOR 6 / 0;
  - NOT 13'h1FFB / 0;
  - SHL 8 / 0;
  - SHR 2 / 0.
- Carry/borrow: ADD x=13'h1FFF, y=1 -> result 0, status 1. SUB x=0, y=1 -> result 13'h1FFF, status 1. With ALU_FUNC_SAT_EN: 13'h1FFF, status 1, and 0, status 1 respectively.
- Shift edges: SHL x=13'h1000 -> result 0, status 1. SHR x=13'h0001 -> result 0, status 1.
- Async reset mid-stream: assert aresetn=0 between edges while opcode=ADD, x=4, y=2 -> outputs drop to 0 immediately, without waiting for aclk. On release, the next edge yields 6.
